// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Brief    : MEM-stage load/store unit. Issues one data-memory access per op,
//             aligns/extends load data, stalls the pipe, flags misalignment
//             and load-response timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_RWAIT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Counter value on the last permitted RWAIT cycle (TIMEOUT must be >= 1).
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [7:0]  r_cnt;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_timeout;

    logic        w_legal;
    logic        w_aligned;
    logic        w_accept;
    logic        w_in_req;
    logic        w_tmo_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // Op decode on the live inputs: only a legal, aligned op is accepted.
    always_comb begin
        w_legal = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
        w_aligned = 1'b1;
        case (funct3_i[1:0])
            2'b01:   w_aligned = ~addr_i[0];
            2'b10:   w_aligned = (addr_i[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_accept  = start_i && w_legal && w_aligned;
    assign w_tmo_hit = (r_state == c_RWAIT) && !dmem_rvalid_i && (r_cnt == c_TMO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next = c_REQ;
            c_REQ:   if (dmem_gnt_i) w_next = r_is_store ? c_DONE : c_RWAIT;
            c_RWAIT: begin
                if (dmem_rvalid_i) w_next = c_DONE;
                else if (w_tmo_hit) w_next = c_IDLE;
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Request-side lane steering from the latched op.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Response-side lane extraction and extension.
    always_comb begin
        w_byte = dmem_rdata_i[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = dmem_rdata_i[7:0];
            2'd1:    w_byte = dmem_rdata_i[15:8];
            2'd2:    w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase
        w_half     = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        w_load_ext = dmem_rdata_i;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= 8'd0;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_misalign <= (r_state == c_IDLE) && start_i && !(w_legal && w_aligned);
            r_timeout  <= w_tmo_hit;
            if (r_state == c_IDLE && start_i) begin
                r_is_store <= is_store_i;
                r_funct3   <= funct3_i;
                r_addr     <= addr_i;
                r_wdata    <= wdata_i;
            end
            if (r_state == c_REQ) begin
                r_cnt <= 8'd0;
            end else if (r_state == c_RWAIT && !dmem_rvalid_i) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == c_RWAIT) begin
                if (dmem_rvalid_i) r_rdata <= w_load_ext;
                else if (w_tmo_hit) r_rdata <= 32'd0;
            end
        end
    end

    assign w_in_req     = (r_state == c_REQ);
    assign dmem_req_o   = w_in_req;
    assign dmem_we_o    = w_in_req && r_is_store;
    assign dmem_be_o    = w_in_req ? w_be : 4'd0;
    assign dmem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_o = w_in_req ? w_wdata : 32'd0;

    assign stall_o    = ((r_state == c_IDLE) && w_accept) || w_in_req || (r_state == c_RWAIT);
    assign done_o     = (r_state == c_DONE);
    assign rdata_o    = r_rdata;
    assign misalign_o = r_misalign;
    assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_lsu
//  Brief    : Directed self-checking bench for mem_lsu (TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        r_rst;
    logic        r_start;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_gnt;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_req;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_daddr;
    logic [31:0] w_dwdata;
    logic        w_stall;
    logic        w_done;
    logic [31:0] w_rdata;
    logic        w_misalign;
    logic        w_timeout;

    int n_pass;
    int n_total;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (r_rst),
        .start_i      (r_start),
        .is_store_i   (r_is_store),
        .funct3_i     (r_funct3),
        .addr_i       (r_addr),
        .wdata_i      (r_wdata),
        .dmem_req_o   (w_req),
        .dmem_we_o    (w_we),
        .dmem_be_o    (w_be),
        .dmem_addr_o  (w_daddr),
        .dmem_wdata_o (w_dwdata),
        .dmem_gnt_i   (r_gnt),
        .dmem_rvalid_i(r_rvalid),
        .dmem_rdata_i (r_rdata),
        .stall_o      (w_stall),
        .done_o       (w_done),
        .rdata_o      (w_rdata),
        .misalign_o   (w_misalign),
        .timeout_o    (w_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Inputs change just after the rising edge; outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        r_start    = 1'b1;
        r_is_store = st;
        r_funct3   = f3;
        r_addr     = a;
        r_wdata    = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},      {31'd0, w_req},      32'd0);
        check({tag, ".we"},       {31'd0, w_we},       32'd0);
        check({tag, ".be"},       {28'd0, w_be},       32'd0);
        check({tag, ".addr"},     w_daddr,             32'd0);
        check({tag, ".wdata"},    w_dwdata,            32'd0);
        check({tag, ".done"},     {31'd0, w_done},     32'd0);
        check({tag, ".rdata"},    w_rdata,             32'd0);
        check({tag, ".misalign"}, {31'd0, w_misalign}, 32'd0);
        check({tag, ".timeout"},  {31'd0, w_timeout},  32'd0);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        r_rst      = 1'b1;
        r_start    = 1'b0;
        r_is_store = 1'b0;
        r_funct3   = 3'd0;
        r_addr     = 32'd0;
        r_wdata    = 32'd0;
        r_gnt      = 1'b0;
        r_rvalid   = 1'b0;
        r_rdata    = 32'd0;
        step(); step();
        sample();
        check_all_zero("reset");
        check("reset.stall", {31'd0, w_stall}, 32'd0);
        step();
        r_rst = 1'b0;

        // LB 0x103: byte 3 of 0x80FF1234 -> 0x80 sign-extended.
        set_op(1'b0, 3'b000, 32'h0000_0103, 32'd0);
        r_gnt = 1'b1;
        sample();
        check("lb.stall_idle", {31'd0, w_stall}, 32'd1);
        check("lb.req_idle", {31'd0, w_req}, 32'd0);
        step();
        r_start = 1'b0;
        sample();
        check("lb.req", {31'd0, w_req}, 32'd1);
        check("lb.we", {31'd0, w_we}, 32'd0);
        check("lb.be", {28'd0, w_be}, 32'h8);
        check("lb.addr", w_daddr, 32'h0000_0100);
        step();
        r_gnt    = 1'b0;
        r_rvalid = 1'b1;
        r_rdata  = 32'h80FF_1234;
        sample();
        check("lb.req_rwait", {31'd0, w_req}, 32'd0);
        check("lb.stall_rwait", {31'd0, w_stall}, 32'd1);
        check("lb.done_early", {31'd0, w_done}, 32'd0);
        step();
        r_rvalid = 1'b0;
        sample();
        check("lb.done", {31'd0, w_done}, 32'd1);
        check("lb.stall_done", {31'd0, w_stall}, 32'd0);
        check("lb.rdata", w_rdata, 32'hFFFF_FF80);
        step();
        sample();
        check("lb.done_once", {31'd0, w_done}, 32'd0);

        // SH 0x0A2 with grant on the fourth REQ cycle.
        set_op(1'b1, 3'b001, 32'h0000_00A2, 32'h0000_BEEF);
        sample();
        check("sh.stall_idle", {31'd0, w_stall}, 32'd1);
        step();
        r_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) r_gnt = 1'b1;
            sample();
            check($sformatf("sh.req%0d", i), {31'd0, w_req}, 32'd1);
            check($sformatf("sh.we%0d", i), {31'd0, w_we}, 32'd1);
            check($sformatf("sh.addr%0d", i), w_daddr, 32'h0000_00A0);
            check($sformatf("sh.be%0d", i), {28'd0, w_be}, 32'hC);
            check($sformatf("sh.wdata%0d", i), w_dwdata, 32'hBEEF_BEEF);
            check($sformatf("sh.stall%0d", i), {31'd0, w_stall}, 32'd1);
            check($sformatf("sh.nodone%0d", i), {31'd0, w_done}, 32'd0);
            step();
        end
        r_gnt = 1'b0;
        sample();
        check("sh.done", {31'd0, w_done}, 32'd1);
        check("sh.req_off", {31'd0, w_req}, 32'd0);
        check("sh.rdata_kept", w_rdata, 32'hFFFF_FF80);
        step();
        sample();
        check("sh.done_once", {31'd0, w_done}, 32'd0);

        // LHU 0x201 (misaligned), then illegal funct3 011.
        set_op(1'b0, 3'b101, 32'h0000_0201, 32'd0);
        sample();
        check("lhu.stall", {31'd0, w_stall}, 32'd0);
        step();
        r_start = 1'b0;
        sample();
        check("lhu.misalign", {31'd0, w_misalign}, 32'd1);
        check("lhu.req", {31'd0, w_req}, 32'd0);
        check("lhu.rdata", w_rdata, 32'hFFFF_FF80);
        step();
        sample();
        check("lhu.misalign_off", {31'd0, w_misalign}, 32'd0);
        check("lhu.req2", {31'd0, w_req}, 32'd0);
        set_op(1'b0, 3'b011, 32'h0000_0200, 32'd0);
        sample();
        check("ill.stall", {31'd0, w_stall}, 32'd0);
        step();
        r_start = 1'b0;
        sample();
        check("ill.misalign", {31'd0, w_misalign}, 32'd1);
        check("ill.req", {31'd0, w_req}, 32'd0);
        check("ill.rdata", w_rdata, 32'hFFFF_FF80);
        step();

        // LW with rvalid withheld: timeout after 4 RWAIT cycles.
        set_op(1'b0, 3'b010, 32'h0000_0300, 32'd0);
        r_gnt = 1'b1;
        step();
        r_start = 1'b0;
        sample();
        check("lw.req", {31'd0, w_req}, 32'd1);
        check("lw.be", {28'd0, w_be}, 32'hF);
        step();
        r_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("lw.stall%0d", i), {31'd0, w_stall}, 32'd1);
            check($sformatf("lw.tmo_early%0d", i), {31'd0, w_timeout}, 32'd0);
            step();
        end
        set_op(1'b0, 3'b010, 32'h0000_0400, 32'd0);
        r_gnt = 1'b1;
        sample();
        check("lw.timeout", {31'd0, w_timeout}, 32'd1);
        check("lw.rdata_zero", w_rdata, 32'd0);
        check("lw.no_done", {31'd0, w_done}, 32'd0);
        check("lw.accept_next", {31'd0, w_stall}, 32'd1);
        step();
        r_start = 1'b0;
        sample();
        check("lw2.req", {31'd0, w_req}, 32'd1);
        check("lw2.addr", w_daddr, 32'h0000_0400);
        check("lw2.timeout_off", {31'd0, w_timeout}, 32'd0);

        // Reset in RWAIT, then a late rvalid.
        step();
        r_gnt = 1'b0;
        r_rst = 1'b1;
        sample();
        check("rst.stall_rwait", {31'd0, w_stall}, 32'd1);
        step();
        sample();
        check_all_zero("rst");
        r_rst = 1'b0;
        step();
        r_rvalid = 1'b1;
        r_rdata  = 32'hDEAD_BEEF;
        sample();
        check("rst.no_done", {31'd0, w_done}, 32'd0);
        check("rst.stall", {31'd0, w_stall}, 32'd0);
        step();
        r_rvalid = 1'b0;
        sample();
        check("rst.no_done2", {31'd0, w_done}, 32'd0);
        check("rst.rdata", w_rdata, 32'd0);

        // Back-to-back: SW then LBU 0x3 with start held through DONE.
        step();
        set_op(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344);
        r_gnt = 1'b1;
        step();
        set_op(1'b0, 3'b100, 32'h0000_0003, 32'd0);
        sample();
        check("sw.we", {31'd0, w_we}, 32'd1);
        check("sw.wdata", w_dwdata, 32'h1122_3344);
        check("sw.addr", w_daddr, 32'h0000_0010);
        step();
        sample();
        check("sw.done", {31'd0, w_done}, 32'd1);
        check("sw.stall_done", {31'd0, w_stall}, 32'd0);
        step();
        sample();
        check("lbu.accept", {31'd0, w_stall}, 32'd1);
        check("lbu.done_off", {31'd0, w_done}, 32'd0);
        step();
        r_start = 1'b0;
        sample();
        check("lbu.req", {31'd0, w_req}, 32'd1);
        check("lbu.be", {28'd0, w_be}, 32'h8);
        check("lbu.addr", w_daddr, 32'd0);
        step();
        r_gnt    = 1'b0;
        r_rvalid = 1'b1;
        r_rdata  = 32'h9A00_0000;
        step();
        r_rvalid = 1'b0;
        sample();
        check("lbu.done", {31'd0, w_done}, 32'd1);
        check("lbu.rdata", w_rdata, 32'h0000_009A);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
